// File: rtl/timestep_sequencer.sv
// timestep_sequencer: instruction register and 2-bit timestep counter.
// It sits in front of the combinational controller. Steps come from a
// debounced Enter button. If AUTO_STEP_EN is defined, a step is taken on
// every clock instead.
// With AUTO_STEP_EN defined, the Enter synchronizer, debounce and arming
// logic are not built.
module timestep_sequencer #(
  parameter int W         = 10,
  parameter int DB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Enter,
  input  logic [W-1:0] Data,
  input  logic         IRin,
  input  logic         Clr,
  output logic [1:0]   T,
  output logic [W-1:0] INST,
  output logic         Step,
  output logic         Done
);

  logic [1:0]   t_q, t_d;
  logic [W-1:0] inst_q, inst_d;
  logic         step_q, step_d;
  logic         done_q, done_d;

`ifdef AUTO_STEP_EN
  // Free-running mode: the button is not used.
  logic unused_enter;
  assign unused_enter = Enter;

  // Step on every clock once reset is released.
  always_comb step_d = 1'b1;
`else
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]    vld_q, vld_d;    // marks when en_s holds a real sample after reset
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          armed_q, armed_d;
  logic          en_s;

  // Button front end: synchronizer, debounce, arming and step detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld_q   <= '0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      armed_q <= armed_d;
    end
  end

  // The debounce counter tracks how long en_s has disagreed with the
  // accepted level. Any agreement restarts the count, so a glitch cannot
  // accumulate. Arming needs a genuine released sample (vld_q[1]), so a
  // button held through reset never arms on the reset value of the
  // synchronizer flops.
  always_comb begin
    sync1_d = Enter;
    sync2_d = sync1_q;
    vld_d   = {vld_q[0], 1'b1};
    en_s    = sync2_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    if (en_s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      db_d  = en_s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    armed_d = armed_q | (vld_q[1] & ~db_q & ~en_s);
    step_d  = armed_q & ~db_q & db_d;
  end
`endif

  // Architectural state: T, INST and the Step/Done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q    <= '0;
      inst_q <= '0;
      step_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      inst_q <= inst_d;
      step_q <= step_d;
      done_q <= done_d;
    end
  end

  // T and INST change only on a step. Clr wins over increment, and IRin
  // applies independently of Clr.
  always_comb begin
    t_d    = t_q;
    inst_d = inst_q;
    done_d = 1'b0;
    if (step_q) begin
      t_d    = Clr ? 2'd0 : t_q + 2'd1;
      done_d = Clr;
      if (IRin) inst_d = Data;
    end
  end

  assign T    = t_q;
  assign INST = inst_q;
  assign Step = step_q;
  assign Done = done_q;

endmodule
